// File: rtl/light_pkg.sv
// Shared types and default tuning for the ambient-light front end of the street light controller.
package light_pkg;
   typedef enum logic [1:0] {DAY, DUSK, NIGHT, DAWN} light_state_t;
   typedef enum {CLS_DARK, CLS_LIGHT, CLS_BAND} sample_class_t;

   localparam int unsigned DEF_ADC_W       = 10;
   localparam int unsigned DEF_DARK_TH     = 200;
   localparam int unsigned DEF_LIGHT_TH    = 300;
   localparam int unsigned DEF_CONFIRM_N   = 4;
   localparam int unsigned DEF_TIMEOUT_CYC = 100000;
endpackage

// File: rtl/sensor_watchdog.sv
// Saturating idle-cycle counter on the ADC stream; timeout stays high while the counter
// sits at TIMEOUT_CYC and drops on the next kick.
module sensor_watchdog
   import light_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic clk_in,
   input  logic reset,
   input  logic kick,
   output logic timeout
);
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         wd_cnt <= '0;
      end else if (kick) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_MAX) begin
         wd_cnt <= wd_cnt + WD_W'(1);
      end
   end

   assign timeout = (wd_cnt == WD_MAX);
endmodule

// File: rtl/light_sensor_conditioner.sv
// Turns raw ambient-light samples into a debounced day/night level with hysteresis,
// N-sample confirmation and a fail-to-night watchdog on the sample stream.
module light_sensor_conditioner
   import light_pkg::*;
#(
   parameter int unsigned ADC_W       = DEF_ADC_W,
   parameter int unsigned DARK_TH     = DEF_DARK_TH,
   parameter int unsigned LIGHT_TH    = DEF_LIGHT_TH,
   parameter int unsigned CONFIRM_N   = DEF_CONFIRM_N,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             adc_valid,
   input  logic [ADC_W-1:0] adc_data,
   output logic             dark_out,
   output logic             change_pulse,
   output logic             sensor_fault
);
   localparam int CNT_W = $clog2(CONFIRM_N + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_N - 1);
   localparam logic [ADC_W-1:0] DARK_V   = ADC_W'(DARK_TH);
   localparam logic [ADC_W-1:0] LIGHT_V  = ADC_W'(LIGHT_TH);

   if (DARK_TH >= LIGHT_TH || CONFIRM_N == 0 || TIMEOUT_CYC < 2) begin : g_param_check
      $error("light_sensor_conditioner: need DARK_TH < LIGHT_TH, CONFIRM_N >= 1, TIMEOUT_CYC >= 2");
   end

   function automatic sample_class_t classify(input logic [ADC_W-1:0] d);
      if (d <= DARK_V)       return CLS_DARK;
      else if (d >= LIGHT_V) return CLS_LIGHT;
      else                   return CLS_BAND;
   endfunction

   light_state_t     state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   sample_class_t    cls;
   logic             wd_timeout;
   logic             dark_nxt, pulse_nxt, fault_nxt;

   sensor_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
      .clk_in  (clk_in),
      .reset   (reset),
      .kick    (adc_valid),
      .timeout (wd_timeout)
   );

   assign cls = classify(adc_data);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state <= DAY;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // A valid sample always takes priority over the watchdog, so a sample arriving on the
   // timeout cycle is classified normally and no fault is raised.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (adc_valid) begin
         unique case (state)
            DAY: begin
               cnt_nxt = '0;
               if (cls == CLS_DARK) begin
                  if (CNT_LAST == '0) state_nxt = NIGHT;
                  else begin
                     state_nxt = DUSK;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            DUSK: begin
               if (cls != CLS_DARK) begin
                  state_nxt = DAY;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = NIGHT;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            NIGHT: begin
               cnt_nxt = '0;
               if (cls == CLS_LIGHT) begin
                  if (CNT_LAST == '0) state_nxt = DAY;
                  else begin
                     state_nxt = DAWN;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            DAWN: begin
               if (cls != CLS_LIGHT) begin
                  state_nxt = NIGHT;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = DAY;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_nxt = DAY;
               cnt_nxt   = '0;
            end
         endcase
      end else if (wd_timeout) begin
         state_nxt = NIGHT;
         cnt_nxt   = '0;
      end
   end

   always_comb begin
      dark_nxt  = (state_nxt == NIGHT) || (state_nxt == DAWN);
      pulse_nxt = (dark_nxt != dark_out);
      fault_nxt = !adc_valid && wd_timeout;
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         dark_out     <= 1'b0;
         change_pulse <= 1'b0;
         sensor_fault <= 1'b0;
      end else begin
         dark_out     <= dark_nxt;
         change_pulse <= pulse_nxt;
         sensor_fault <= fault_nxt;
      end
   end
endmodule

// File: tb/tb_light_sensor_conditioner.sv
// Scoreboard bench: stimulus queues the expected {dark_out, change_pulse, sensor_fault}
// for each checked cycle; the monitor pops and compares one cycle later.
module tb_light_sensor_conditioner;
   localparam int unsigned ADC_W = 10;

   logic             clk_in = 1'b0;
   logic             reset;
   logic             adc_valid;
   logic [ADC_W-1:0] adc_data;
   logic             dark_out, change_pulse, sensor_fault;

   always #5 clk_in = ~clk_in;

   light_sensor_conditioner #(
      .ADC_W(10), .DARK_TH(200), .LIGHT_TH(300), .CONFIRM_N(4), .TIMEOUT_CYC(50)
   ) dut (
      .clk_in       (clk_in),
      .reset        (reset),
      .adc_valid    (adc_valid),
      .adc_data     (adc_data),
      .dark_out     (dark_out),
      .change_pulse (change_pulse),
      .sensor_fault (sensor_fault)
   );

   typedef struct {
      string      name;
      logic [2:0] exp;
   } exp_t;

   exp_t sb_q[$];
   logic chk = 1'b0;
   logic chk_p1 = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk_in) chk_p1 <= chk;

   always @(negedge clk_in) begin : monitor
      exp_t       e;
      logic [2:0] act;
      if (chk_p1) begin
         act = {dark_out, change_pulse, sensor_fault};
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output: got dark/pulse/fault=%b with no expectation queued", act);
         end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
               failures++;
               $display("FAIL %s: got dark/pulse/fault=%b required=%b", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic step(input logic v, input logic [ADC_W-1:0] d, input logic [2:0] e,
                       input string nm);
      @(negedge clk_in);
      reset     = 1'b0;
      adc_valid = v;
      adc_data  = d;
      chk       = 1'b1;
      sb_q.push_back('{name: nm, exp: e});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_in);
         reset     = 1'b0;
         adc_valid = 1'b0;
         chk       = 1'b0;
      end
   endtask

   task automatic reset_cycle(input logic v, input logic do_chk, input string nm);
      @(negedge clk_in);
      reset     = 1'b1;
      adc_valid = v;
      adc_data  = 10'd150;
      chk       = do_chk;
      if (do_chk) sb_q.push_back('{name: nm, exp: 3'b000});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL sim_timeout: run did not complete, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      adc_valid = 1'b0;
      adc_data  = '0;

      // reset held 3 cycles with adc_valid toggling
      reset_cycle(1'b1, 1'b0, "");
      reset_cycle(1'b0, 1'b0, "");
      reset_cycle(1'b1, 1'b1, "reset_state");
      idle(1);

      // dusk: four dark samples from DAY
      step(1, 10'd150, 3'b000, "dusk_1");
      step(1, 10'd150, 3'b000, "dusk_2");
      step(1, 10'd150, 3'b000, "dusk_3");
      step(1, 10'd150, 3'b110, "dusk_4_to_night");
      step(0, 10'd0,   3'b100, "dusk_pulse_once");

      // band and boundary samples while NIGHT
      step(1, 10'd250, 3'b100, "night_band_a");
      step(1, 10'd250, 3'b100, "night_band_b");
      step(1, 10'd200, 3'b100, "night_dark_th");
      step(1, 10'd300, 3'b100, "night_light_th_dawn");
      step(1, 10'd299, 3'b100, "dawn_band_abort");

      // dawn: four light samples
      step(1, 10'd800, 3'b100, "dawn_1");
      step(1, 10'd800, 3'b100, "dawn_2");
      step(1, 10'd800, 3'b100, "dawn_3");
      step(1, 10'd800, 3'b010, "dawn_4_to_day");
      step(0, 10'd0,   3'b000, "dawn_pulse_once");

      // flicker from DAY
      step(1, 10'd150, 3'b000, "flicker_1");
      step(1, 10'd150, 3'b000, "flicker_2");
      step(1, 10'd150, 3'b000, "flicker_3");
      step(1, 10'd350, 3'b000, "flicker_light");
      step(1, 10'd150, 3'b000, "flicker_5");
      step(1, 10'd201, 3'b000, "dusk_band_abort");

      // DARK_TH is inclusive
      step(1, 10'd200, 3'b000, "dark_th_1");
      step(1, 10'd200, 3'b000, "dark_th_2");
      step(1, 10'd200, 3'b000, "dark_th_3");
      step(1, 10'd200, 3'b110, "dark_th_4_to_night");

      // dawn interrupted by a dark sample
      step(1, 10'd800, 3'b100, "dawn_abort_1");
      step(1, 10'd800, 3'b100, "dawn_abort_2");
      step(1, 10'd800, 3'b100, "dawn_abort_3");
      step(1, 10'd100, 3'b100, "dawn_abort_dark");

      // LIGHT_TH is inclusive
      step(1, 10'd300, 3'b100, "light_th_1");
      step(1, 10'd300, 3'b100, "light_th_2");
      step(1, 10'd300, 3'b100, "light_th_3");
      step(1, 10'd300, 3'b010, "light_th_4_to_day");

      // watchdog: counter saturates on the 50th idle edge, fault registers on the next
      idle(49);
      step(0, 10'd0,   3'b000, "wd_saturate_no_fault_yet");
      step(0, 10'd0,   3'b111, "wd_fault_night_pulse");
      step(0, 10'd0,   3'b101, "wd_fault_hold");
      step(1, 10'd800, 3'b100, "wd_clear_dawn_1");
      step(1, 10'd800, 3'b100, "wd_dawn_2");
      step(1, 10'd800, 3'b100, "wd_dawn_3");
      step(1, 10'd800, 3'b010, "wd_dawn_4_to_day");

      // races: valid on the edge the counter would reach its limit, and right after it
      idle(49);
      step(1, 10'd150, 3'b000, "race_valid_at_limit");
      idle(49);
      step(0, 10'd0,   3'b000, "race_saturated_idle");
      step(1, 10'd800, 3'b000, "race_valid_beats_fault");
      step(0, 10'd0,   3'b000, "race_no_fault_after");

      // reset mid-dusk discards the pending count
      step(1, 10'd150, 3'b000, "rdusk_1");
      step(1, 10'd150, 3'b000, "rdusk_2");
      step(1, 10'd150, 3'b000, "rdusk_3");
      reset_cycle(1'b1, 1'b1, "rdusk_reset");
      step(1, 10'd150, 3'b000, "rdusk_after_reset");
      step(0, 10'd0,   3'b000, "rdusk_still_day");

      idle(3);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
